// File: rtl/boot_loader.sv
// boot_loader: assembles a little-endian byte stream into frames that load IMEM/DMEM
// and finally release the CPU. Frame checksum checking is enabled by BOOT_LOADER_CHECKSUM_EN.
module boot_loader #(
  parameter int IMEM_ADDR_W = 9,
  parameter int DMEM_ADDR_W = 10
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [31:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [31:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [31:0] wdata_ext_2,
  output logic        cpu_enable,
  output logic        busy,
  output logic        error,
  output logic [1:0]  err_code
);

`ifdef BOOT_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_HDR = 3'd0, S_BASE = 3'd1, S_DATA = 3'd2, S_CSUM = 3'd3, S_RUN = 3'd4, S_ERROR = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_HDR = 3'd0, S_BASE = 3'd1, S_DATA = 3'd2, S_RUN = 3'd4, S_ERROR = 3'd5
  } state_t;
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  state_t      w_frame_end;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_word;
  logic        r_sel_dmem;
  logic [15:0] r_count;
  logic [31:0] r_addr;
  logic [31:0] r_addr_ext, r_wdata_ext, r_addr_ext_2, r_wdata_ext_2;
  logic        r_wen_ext, r_wen_ext_2;
  logic        r_error;
  logic [1:0]  r_err_code;
  logic        w_accept, w_word_done, w_in_range, w_wr, w_set_err;
  logic [1:0]  w_err_code;
  logic [31:0] w_word;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [31:0] r_csum;
  assign w_frame_end = S_CSUM;
`else
  assign w_frame_end = S_HDR;
`endif

  assign w_accept    = in_valid && in_ready;
  assign w_word_done = w_accept && (r_byte_cnt == 2'd3);
  assign w_word      = {in_data, r_word};
  assign w_in_range  = r_sel_dmem ? (r_addr[31:DMEM_ADDR_W+2] == {(30-DMEM_ADDR_W){1'b0}})
                                  : (r_addr[31:IMEM_ADDR_W+2] == {(30-IMEM_ADDR_W){1'b0}});

  assign in_ready    = (r_state != S_RUN) && (r_state != S_ERROR);
  assign busy        = (r_state != S_HDR) && in_ready;
  assign cpu_enable  = (r_state == S_RUN);
  assign addr_ext    = r_addr_ext;
  assign wen_ext     = r_wen_ext;
  assign ren_ext     = 1'b0;
  assign wdata_ext   = r_wdata_ext;
  assign addr_ext_2  = r_addr_ext_2;
  assign wen_ext_2   = r_wen_ext_2;
  assign ren_ext_2   = 1'b0;
  assign wdata_ext_2 = r_wdata_ext_2;
  assign error       = r_error;
  assign err_code    = r_err_code;

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_state <= S_HDR;
    else         r_state <= w_state_nxt;
  end

  // Next-state, write-enable and error decode on each completed word
  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_set_err   = 1'b0;
    w_err_code  = 2'b00;
    if (w_word_done) begin
      case (r_state)
        S_HDR: begin
          case (w_word[31:24])
            8'hB0, 8'hB1: w_state_nxt = S_BASE;
            8'hB2:        w_state_nxt = S_RUN;
            default: begin
              w_state_nxt = S_ERROR;
              w_set_err   = 1'b1;
              w_err_code  = 2'b01;
            end
          endcase
        end
        S_BASE: begin
          if (r_count != 16'd0) w_state_nxt = S_DATA;
          else                  w_state_nxt = w_frame_end;
        end
        S_DATA: begin
          if (w_in_range) begin
            w_wr = 1'b1;
            if (r_count == 16'd1) w_state_nxt = w_frame_end;
            else                  w_state_nxt = S_DATA;
          end else begin
            w_state_nxt = S_ERROR;
            w_set_err   = 1'b1;
            w_err_code  = 2'b10;
          end
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (w_word == r_csum) begin
            w_state_nxt = S_HDR;
          end else begin
            w_state_nxt = S_ERROR;
            w_set_err   = 1'b1;
            w_err_code  = 2'b11;
          end
        end
`endif
        default: w_state_nxt = r_state;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Byte assembly, frame bookkeeping, registered memory ports and sticky error
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_byte_cnt    <= 2'd0;
      r_word        <= 24'd0;
      r_sel_dmem    <= 1'b0;
      r_count       <= 16'd0;
      r_addr        <= 32'd0;
      r_addr_ext    <= 32'd0;
      r_wdata_ext   <= 32'd0;
      r_wen_ext     <= 1'b0;
      r_addr_ext_2  <= 32'd0;
      r_wdata_ext_2 <= 32'd0;
      r_wen_ext_2   <= 1'b0;
      r_error       <= 1'b0;
      r_err_code    <= 2'b00;
`ifdef BOOT_LOADER_CHECKSUM_EN
      r_csum        <= 32'd0;
`endif
    end else begin
      if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        case (r_byte_cnt)
          2'd0:    r_word[7:0]   <= in_data;
          2'd1:    r_word[15:8]  <= in_data;
          2'd2:    r_word[23:16] <= in_data;
          default: r_word        <= r_word;
        endcase
      end
      if (w_word_done) begin
        case (r_state)
          S_HDR: begin
            r_sel_dmem <= (w_word[31:24] == 8'hB1);
            r_count    <= w_word[15:0];
`ifdef BOOT_LOADER_CHECKSUM_EN
            r_csum     <= 32'd0;
`endif
          end
          S_BASE: r_addr <= {w_word[31:2], 2'b00};
          S_DATA: begin
            r_count <= r_count - 16'd1;
            r_addr  <= r_addr + 32'd4;
`ifdef BOOT_LOADER_CHECKSUM_EN
            r_csum  <= r_csum + w_word;
`endif
          end
          default: r_count <= r_count;
        endcase
      end
      // The unselected port keeps its last address/data; only its strobe drops
      r_wen_ext   <= w_wr && !r_sel_dmem;
      r_wen_ext_2 <= w_wr && r_sel_dmem;
      if (w_wr && !r_sel_dmem) begin
        r_addr_ext  <= r_addr;
        r_wdata_ext <= w_word;
      end
      if (w_wr && r_sel_dmem) begin
        r_addr_ext_2  <= r_addr;
        r_wdata_ext_2 <= w_word;
      end
      if (w_set_err && !r_error) begin
        r_error    <= 1'b1;
        r_err_code <= w_err_code;
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: loads, run, bad opcode, DMEM range, checksum, gaps and reset.
module tb_boot_loader;
  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic        cpu_enable, busy, error;
  logic [1:0]  err_code;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] q_ia[$], q_id[$], q_da[$], q_dd[$];
  int ni, nd;

  always #5 clk = ~clk;

  boot_loader #(.IMEM_ADDR_W(9), .DMEM_ADDR_W(10)) dut (
    .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2),
    .cpu_enable(cpu_enable), .busy(busy), .error(error), .err_code(err_code)
  );

  // Record every write strobe once per cycle, sampled away from the active edge
  always @(negedge clk) begin
    if (wen_ext === 1'b1) begin q_ia.push_back(addr_ext); q_id.push_back(wdata_ext); end
    if (wen_ext_2 === 1'b1) begin q_da.push_back(addr_ext_2); q_dd.push_back(wdata_ext_2); end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic send_word_gap(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8]);
      in_valid = 1'b0;
      in_data  = 8'hEE;
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    arst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) arst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    do_reset();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_outs", {cpu_enable, busy, error, err_code, wen_ext, wen_ext_2, ren_ext, ren_ext_2}, 32'd0);
    chk("rst_ports", addr_ext | wdata_ext | addr_ext_2 | wdata_ext_2, 32'd0);

    // IMEM load, back-to-back bytes
    send_word(32'hB000_0002);
    chk("t1_busy_base", {31'd0, busy}, 32'd1);
    send_word(32'h0000_0000);
    chk("t1_no_wen_base", {31'd0, wen_ext}, 32'd0);
    send_word(32'h2008_0005);
    chk("t1_w0", {wen_ext, wen_ext_2, 30'd0}, 32'h8000_0000);
    chk("t1_a0", addr_ext, 32'h0);
    chk("t1_d0", wdata_ext, 32'h2008_0005);
    send_word(32'h0109_5020);
    chk("t1_w1", {31'd0, wen_ext}, 32'd1);
    chk("t1_a1", addr_ext, 32'h4);
    chk("t1_d1", wdata_ext, 32'h0109_5020);
`ifdef BOOT_LOADER_CHECKSUM_EN
    send_word(32'h2111_5025);
`endif
    idle(1);
    chk("t1_wen_drop", {31'd0, wen_ext}, 32'd0);
    chk("t1_busy_done", {busy, error, in_ready}, 32'd1);
    chk("t1_imem_cnt", q_ia.size(), 32'd2);
    chk("t1_dmem_cnt", q_da.size(), 32'd0);

    // Empty frame returns straight to header parsing
    send_word(32'hB000_0000);
    send_word(32'h0000_0100);
`ifdef BOOT_LOADER_CHECKSUM_EN
    send_word(32'h0000_0000);
`endif
    idle(1);
    chk("n0_idle", {busy, error, in_ready}, 32'd1);

    // Run
    send_word(32'hB200_0000);
    chk("t2_cpu_en", {cpu_enable, in_ready, busy}, 32'd4);
    send_word(32'hB000_0001);
    idle(2);
    chk("t2_stays_run", {cpu_enable, in_ready, error}, 32'd4);
    chk("t2_no_writes", q_ia.size(), 32'd2);

    // Bad opcode, then async reset clears it
    do_reset();
    send_word(32'h5500_0000);
    chk("t3_err", {error, err_code, in_ready, busy}, 32'b1_01_0_0);
    idle(1);
    arst_n = 1'b0;
    #1;
    chk("t3_rst_clear", {error, err_code, cpu_enable, busy}, 32'd0);
    chk("t3_no_writes", q_ia.size() + q_da.size(), 32'd2);
    @(negedge clk) arst_n = 1'b1;
    @(posedge clk); #1;

    // DMEM range boundary
    nd = q_da.size();
    send_word(32'hB100_0002);
    send_word(32'h0000_0FFC);
    send_word(32'h1111_1111);
    chk("t4_w_last", {wen_ext_2, wen_ext, error}, 32'b100);
    chk("t4_a_last", addr_ext_2, 32'h0000_0FFC);
    chk("t4_d_last", wdata_ext_2, 32'h1111_1111);
    send_word(32'h2222_2222);
    chk("t4_suppr", {wen_ext_2, wen_ext, error, err_code, in_ready}, 32'b0_0_1_10_0);
    idle(2);
    chk("t4_dmem_cnt", q_da.size() - nd, 32'd1);
    chk("t4_code_kept", {30'd0, err_code}, 32'd2);

`ifdef BOOT_LOADER_CHECKSUM_EN
    // Checksum match then mismatch (sum 0xFFFFFFFF + 2 = 1 mod 2^32)
    do_reset();
    send_word(32'hB100_0002);
    send_word(32'h0000_0010);
    send_word(32'hFFFF_FFFF);
    send_word(32'h0000_0002);
    send_word(32'h0000_0001);
    chk("t5_match", {busy, error, in_ready}, 32'd1);
    send_word(32'hB100_0002);
    send_word(32'h0000_0010);
    send_word(32'hFFFF_FFFF);
    send_word(32'h0000_0002);
    send_word(32'h0000_0003);
    chk("t5_mismatch", {error, err_code, in_ready}, 32'b1_11_0);
`endif

    // Input gaps give the same writes as the back-to-back load
    do_reset();
    ni = q_ia.size();
    send_word_gap(32'hB000_0002);
    send_word_gap(32'h0000_0000);
    send_word_gap(32'h2008_0005);
    send_word_gap(32'h0109_5020);
`ifdef BOOT_LOADER_CHECKSUM_EN
    send_word_gap(32'h2111_5025);
`endif
    idle(1);
    chk("t6_gap_cnt", q_ia.size() - ni, 32'd2);
    if (q_ia.size() - ni == 2) begin
      chk("t6_gap_a0", q_ia[ni], 32'h0);
      chk("t6_gap_d0", q_id[ni], 32'h2008_0005);
      chk("t6_gap_a1", q_ia[ni+1], 32'h4);
      chk("t6_gap_d1", q_id[ni+1], 32'h0109_5020);
    end
    chk("t6_gap_idle", {busy, error, in_ready}, 32'd1);

    // Reset in the middle of a payload word discards it
    ni = q_ia.size();
    send_word(32'hB000_0001);
    send_word(32'h0000_0020);
    send_byte(8'h78);
    send_byte(8'h56);
    in_valid = 1'b0;
    arst_n = 1'b0;
    @(posedge clk); #1;
    arst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_state", {busy, error, in_ready, wen_ext}, 32'b0010);
    send_word(32'hB200_0000);
    chk("t6_hdr_after_rst", {cpu_enable, in_ready}, 32'b10);
    idle(2);
    chk("t6_no_strobe", q_ia.size() - ni, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
